key_sw_conditioner: RTL and testbench
=====================================

Name: key_sw_conditioner

Overview:
- Input-conditioning stage between the board's raw push buttons and toggle switches and the board I/O block.
- Synchronises and debounces key[3:0] and sw[9:0]. Outputs clean, polarity-preserving key_db and sw_db to the board I/O block's key and sw inputs.
- Latches debounced key-press events in a sticky register on the J1 I/O bus: readable at address KEYEV, write-1-to-clear.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable clocks required to accept a new level (10 ms at 50 MHz); minimum 2.
- KEY_ACTIVE_LOW, 1, 1 = key pressed reads 0 (board buttons); 0 = pressed reads 1.

Ports:
- clk  in  1  system clock (same as J1 io.clk)
- reset  in  1  reset; synchronous, active-high
- key_raw  in  4  asynchronous push-button pins
- sw_raw  in  10  asynchronous toggle-switch pins
- key_db  out  4  debounced keys, raw polarity, to board I/O key input
- sw_db  out  10  debounced switches, to board I/O sw input
- io_rd  in  1  J1 read strobe
- io_wr  in  1  J1 write strobe
- io_addr  in  16  J1 I/O address
- io_dout  in  16  J1 write data
- io_din  out  16  J1 read data; OR-bus contribution
- key_irq  out  1  OR of all event bits (level)

Behaviour:
- Reset values:
  - Sync flops and key_db = inactive level (4'hF if KEY_ACTIVE_LOW, else 4'h0).
  - sw_db and sw sync flops = 0.
  - All debounce counters = 0; event register = 0; key_irq = 0.
- Reset asserted mid-bounce aborts the count; no event is generated by reset entry or exit.
- Per channel (14 total, identical):
  - 2-flop synchroniser s1->s2.
  - If s2 != stable: counter increments.
  - If counter == DEBOUNCE_CYCLES-1 and s2 != stable: stable <= s2, counter <= 0.
  - If s2 == stable: counter <= 0, so any glitch restarts the count.
  - Counter width is $clog2(DEBOUNCE_CYCLES); no wrap is possible.
- Latency: a clean raw level change appears on the db output DEBOUNCE_CYCLES+2 rising edges after the first edge that samples it. Pulses shorter than DEBOUNCE_CYCLES clocks never propagate.
- Press event (keys only):
  - Set when a key's stable value transitions inactive->active.
  - ev[i] sets on the same edge key_db[i] changes and is visible with it.
- Event register ev[3:0]:
  - Sticky.
  - Write: when io_wr && io_addr==KEYEV, bits with io_dout[i]=1 clear.
  - A set and a clear of the same bit in the same cycle: set wins. A write to any other address has no effect.
  - Reads do not clear.
- io_din (combinational):
  - 16'b0 unless io_rd && io_addr==KEYEV.
  - When selected: {12'b0, ev[3:0]}, or {8'b0, rel[3:0], ev[3:0]} with the optional feature.
- key_irq = |ev (plus |rel with the optional feature); registered-state derived, no combinational path from io inputs.
- Simultaneous events on several keys all latch in the same cycle.

Optional Feature:
- Macro: KEY_RELEASE_EV_EN.
- Defined:
  - Adds rel[3:0], set on debounced active->inactive transitions.
  - Read at KEYEV bits [7:4]; cleared by writing 1 to io_dout[7:4]; same set-wins rule; included in key_irq.
- Undefined:
  - No release logic.
  - Bits [7:4] read 0; writes to them are ignored.

Decomposition:
- Package ioaddr gains constant KEYEV (next free I/O address beside KEY/SW).
- Same package gains KEY_EV_W = 4 and SW_W = 10.
- Sub-module debounce_bit (params DEBOUNCE_CYCLES, RESET_VAL), instantiated 14 times via generate. It contains the synchroniser, counter and stable register, and outputs stable plus a one-cycle rise/fall strobe.
- Top level holds the event register and bus decode.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and KEY_ACTIVE_LOW=1.
- Reset: hold reset 3 clks with key_raw=4'h0, sw_raw=10'h3FF -> key_db=4'hF, sw_db=0, ev=0, io_din=0 during reset; after release, key_db=4'h0 and sw_db=10'h3FF exactly 6 edges later, ev[3:0]=4'hF (presses).
- Clean press: key_raw[2] 1->0 held -> key_db[2] falls 6 edges later; same edge ev[2]=1 and key_irq=1; read at KEYEV returns 16'h0004.
- Glitch reject: key_raw[0] low for 3 clks then high, repeated -> key_db[0] stays 1; ev stays 0; sw bounce 1-0-1 at 2-clk spacing -> sw_db unchanged.
- W1C and collision: ev=4'b0101; write 16'h0001 -> ev=4'b0100. Write 16'h0004 on the same edge key 2 re-presses -> ev[2] remains 1.
- Bus isolation: io_rd with addr != KEYEV -> io_din=16'h0000. io_wr to another address with dout=16'hFFFF -> ev unchanged.
- KEY_RELEASE_EV_EN: press then release key 1 -> read KEYEV = 16'h0022. Write 16'h0020 -> 16'h0002. Without the macro, the same stimulus reads 16'h0002.

Source files
------------

// File: rtl/key_sw_conditioner_pkg.sv
// key_sw_conditioner_pkg: I/O map and widths for the key/switch conditioner.
// KEYEV sits next to the KEY and SW input ports.
package key_sw_conditioner_pkg;

  localparam logic [15:0] IO_KEY = 16'h0004;
  localparam logic [15:0] IO_SW  = 16'h0008;
  localparam logic [15:0] KEYEV  = 16'h000C;

  localparam int KEY_EV_W = 4;
  localparam int SW_W     = 10;

endpackage

// File: rtl/key_sw_conditioner_if.sv
// key_sw_conditioner_if: J1 I/O bus slice seen by the conditioner.
// The master drives strobes, address and write data; the slave returns read data.
interface key_sw_conditioner_if;

  logic        io_rd;
  logic        io_wr;
  logic [15:0] io_addr;
  logic [15:0] io_dout;
  logic [15:0] io_din;

  modport master (
    output io_rd,
    output io_wr,
    output io_addr,
    output io_dout,
    input  io_din
  );

  modport slave (
    input  io_rd,
    input  io_wr,
    input  io_addr,
    input  io_dout,
    output io_din
  );

endinterface

// File: rtl/debounce_bit.sv
// debounce_bit: 2-flop synchroniser, stability counter and stable level.
// rise_o/fall_o pulse in the cycle whose clock edge updates stable_o.
module debounce_bit #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter logic        RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q;
  logic          s2_q;
  logic          stable_q;
  logic          stable_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          diff;
  logic          done;

  assign diff = s2_q ^ stable_q;
  assign done = diff && (cnt_q == LAST);

  // any sample matching the stable level restarts the count
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (done) begin
      stable_d = s2_q;
    end else if (diff) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q     <= RESET_VAL;
      s2_q     <= RESET_VAL;
      stable_q <= RESET_VAL;
      cnt_q    <= '0;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = done & s2_q & ~reset;
  assign fall_o   = done & ~s2_q & ~reset;

endmodule

// File: rtl/key_sw_conditioner.sv
// key_sw_conditioner: debounces keys/switches, latches press events at KEYEV.
// Define KEY_RELEASE_EV_EN to also latch release events in KEYEV bits [7:4].
module key_sw_conditioner
  import key_sw_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [KEY_EV_W-1:0] key_raw,
  input  logic [SW_W-1:0]     sw_raw,
  output logic [KEY_EV_W-1:0] key_db,
  output logic [SW_W-1:0]     sw_db,
  key_sw_conditioner_if.slave io,
  output logic                key_irq
);

  logic [KEY_EV_W-1:0] k_rise;
  logic [KEY_EV_W-1:0] k_fall;
  logic [KEY_EV_W-1:0] press;
  logic [KEY_EV_W-1:0] clr;
  logic [KEY_EV_W-1:0] ev_q;
  logic [KEY_EV_W-1:0] ev_d;
  logic [SW_W-1:0]     sw_rise;
  logic [SW_W-1:0]     sw_fall;
  logic                sel;
  logic                wsel;
  logic                edge_unused;

  for (genvar i = 0; i < KEY_EV_W; i++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (KEY_ACTIVE_LOW)
    ) u_db (
      .clk      (clk),
      .reset    (reset),
      .raw_i    (key_raw[i]),
      .stable_o (key_db[i]),
      .rise_o   (k_rise[i]),
      .fall_o   (k_fall[i])
    );
  end

  for (genvar i = 0; i < SW_W; i++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (1'b0)
    ) u_db (
      .clk      (clk),
      .reset    (reset),
      .raw_i    (sw_raw[i]),
      .stable_o (sw_db[i]),
      .rise_o   (sw_rise[i]),
      .fall_o   (sw_fall[i])
    );
  end

  assign edge_unused = ^{sw_rise, sw_fall};

  assign press = KEY_ACTIVE_LOW ? k_fall : k_rise;
  assign sel   = io.io_addr == KEYEV;
  assign wsel  = io.io_wr && sel;
  assign clr   = wsel ? io.io_dout[KEY_EV_W-1:0] : '0;

  // a new press outranks a clear landing on the same edge
  assign ev_d = (ev_q & ~clr) | press;

  always_ff @(posedge clk) begin
    if (reset) begin
      ev_q <= '0;
    end else begin
      ev_q <= ev_d;
    end
  end

`ifdef KEY_RELEASE_EV_EN
  logic [KEY_EV_W-1:0] relse;
  logic [KEY_EV_W-1:0] rclr;
  logic [KEY_EV_W-1:0] rel_q;
  logic [KEY_EV_W-1:0] rel_d;
  logic [7:0]          dout_unused;

  assign relse = KEY_ACTIVE_LOW ? k_rise : k_fall;
  assign rclr  = wsel ? io.io_dout[2*KEY_EV_W-1:KEY_EV_W] : '0;
  assign rel_d = (rel_q & ~rclr) | relse;

  always_ff @(posedge clk) begin
    if (reset) begin
      rel_q <= '0;
    end else begin
      rel_q <= rel_d;
    end
  end

  assign io.io_din   = (io.io_rd && sel) ? {8'h00, rel_q, ev_q} : 16'h0000;
  assign key_irq     = |{rel_q, ev_q};
  assign dout_unused = io.io_dout[15:8];
`else
  logic [11:0] dout_unused;

  assign io.io_din   = (io.io_rd && sel) ? {12'h000, ev_q} : 16'h0000;
  assign key_irq     = |ev_q;
  assign dout_unused = io.io_dout[15:4];
`endif

endmodule

// File: tb/tb_key_sw_conditioner.sv
// tb_key_sw_conditioner: directed table plus randomized run against a
// sample-history reference model (DEBOUNCE_CYCLES=4, active-low keys).
module tb_key_sw_conditioner;
  import key_sw_conditioner_pkg::*;

  localparam int unsigned DB  = 4;
  localparam bit          KAL = 1'b1;
  localparam int          NCH = KEY_EV_W + SW_W;
`ifdef KEY_RELEASE_EV_EN
  localparam bit REL_EN = 1'b1;
`else
  localparam bit REL_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic [3:0] key_raw;
  logic [9:0] sw_raw;
  logic [3:0] key_db;
  logic [9:0] sw_db;
  logic       key_irq;

  key_sw_conditioner_if io ();

  key_sw_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .KEY_ACTIVE_LOW  (KAL)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .key_raw (key_raw),
    .sw_raw  (sw_raw),
    .key_db  (key_db),
    .sw_db   (sw_db),
    .io      (io),
    .key_irq (key_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // raw sample history per channel, index 0 = newest
  bit         h   [NCH][DB+1];
  bit         mdb [NCH];
  logic [3:0] mev;
  logic [3:0] mrel;

  typedef struct {
    bit          rst;
    logic [3:0]  kr;
    logic [9:0]  sr;
    bit          rd;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] dout;
    int          n;
    logic [3:0]  ek;
    logic [9:0]  es;
    logic [15:0] ed;
    bit          ei;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit rst, logic [3:0] kr, logic [9:0] sr,
                              bit rd, bit wr, logic [15:0] addr,
                              logic [15:0] dout, int n, logic [3:0] ek,
                              logic [9:0] es, logic [15:0] ed, bit ei);
    vec_t v;
    v.rst = rst; v.kr = kr; v.sr = sr; v.rd = rd; v.wr = wr;
    v.addr = addr; v.dout = dout; v.n = n;
    v.ek = ek; v.es = es; v.ed = ed; v.ei = ei;
    return v;
  endfunction

  function automatic logic [15:0] rx(logic [15:0] w, logic [15:0] wo);
    return REL_EN ? w : wo;
  endfunction

  function automatic bit rv(int c);
    return (c < KEY_EV_W) ? KAL : 1'b0;
  endfunction

  task automatic check(string nm, logic [15:0] act, logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // a channel flips once its delayed samples have all shown the other level
  task automatic model_step(bit rst, logic [13:0] raw, bit wr,
                            logic [15:0] addr, logic [15:0] dout);
    logic [3:0] pr, rl, clr, rclr;
    bit flip;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        for (int j = 0; j <= DB; j++) h[c][j] = rv(c);
        mdb[c] = rv(c);
      end
      mev = '0;
      mrel = '0;
      return;
    end
    pr = '0;
    rl = '0;
    for (int c = 0; c < NCH; c++) begin
      flip = 1'b1;
      for (int j = 1; j <= DB; j++)
        if (h[c][j] == mdb[c]) flip = 1'b0;
      if (flip) begin
        mdb[c] = ~mdb[c];
        if (c < KEY_EV_W) begin
          if (mdb[c] != KAL) pr[c[1:0]] = 1'b1;
          else rl[c[1:0]] = 1'b1;
        end
      end
      for (int j = DB; j > 0; j--) h[c][j] = h[c][j-1];
      h[c][0] = raw[c];
    end
    clr  = (wr && addr == KEYEV) ? dout[3:0] : 4'h0;
    rclr = (wr && addr == KEYEV) ? dout[7:4] : 4'h0;
    mev = (mev & ~clr) | pr;
    if (REL_EN) mrel = (mrel & ~rclr) | rl;
  endtask

  task automatic compare_model();
    logic [13:0] p;
    logic [15:0] ed;
    bit ei;
    for (int c = 0; c < NCH; c++) p[c] = mdb[c];
    ed = (io.io_rd && io.io_addr == KEYEV)
         ? {8'h00, (REL_EN ? mrel : 4'h0), mev} : 16'h0000;
    ei = (|mev) || (REL_EN && (|mrel));
    check("model key_db", {12'h000, key_db}, {12'h000, p[3:0]});
    check("model sw_db", {6'h00, sw_db}, {6'h00, p[13:4]});
    check("model io_din", io.io_din, ed);
    check("model key_irq", {15'h0, key_irq}, {15'h0, ei});
  endtask

  task automatic tick();
    bit r, w;
    logic [13:0] raw;
    logic [15:0] a, d;
    r   = reset;
    raw = {sw_raw, key_raw};
    w   = io.io_wr;
    a   = io.io_addr;
    d   = io.io_dout;
    @(posedge clk);
    model_step(r, raw, w, a, d);
    @(negedge clk);
    compare_model();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    key_raw = 4'h0;
    sw_raw = 10'h3FF;
    io.io_rd = 1'b0;
    io.io_wr = 1'b0;
    io.io_addr = 16'h0000;
    io.io_dout = 16'h0000;

    tbl.push_back(mk(1, 4'h0, 10'h3FF, 1, 0, KEYEV, 16'h0, 3, 4'hF, 10'h000, 16'h0000, 0));
    tbl.push_back(mk(0, 4'h0, 10'h3FF, 1, 0, KEYEV, 16'h0, 5, 4'hF, 10'h000, 16'h0000, 0));
    tbl.push_back(mk(0, 4'h0, 10'h3FF, 1, 0, KEYEV, 16'h0, 1, 4'h0, 10'h3FF, 16'h000F, 1));
    tbl.push_back(mk(0, 4'h0, 10'h3FF, 1, 1, KEYEV, 16'hFFFF, 1, 4'h0, 10'h3FF, 16'h0000, 0));
    tbl.push_back(mk(0, 4'hF, 10'h3FF, 1, 0, KEYEV, 16'h0, 6, 4'hF, 10'h3FF, rx(16'h00F0, 16'h0), REL_EN));
    tbl.push_back(mk(0, 4'hF, 10'h3FF, 1, 1, KEYEV, 16'hFFFF, 1, 4'hF, 10'h3FF, 16'h0000, 0));
    tbl.push_back(mk(0, 4'hB, 10'h3FF, 1, 0, KEYEV, 16'h0, 5, 4'hF, 10'h3FF, 16'h0000, 0));
    tbl.push_back(mk(0, 4'hB, 10'h3FF, 1, 0, KEYEV, 16'h0, 1, 4'hB, 10'h3FF, 16'h0004, 1));
    tbl.push_back(mk(0, 4'hA, 10'h3FF, 1, 0, KEYEV, 16'h0, 3, 4'hB, 10'h3FF, 16'h0004, 1));
    tbl.push_back(mk(0, 4'hB, 10'h3FF, 1, 0, KEYEV, 16'h0, 3, 4'hB, 10'h3FF, 16'h0004, 1));
    tbl.push_back(mk(0, 4'hA, 10'h3FF, 1, 0, KEYEV, 16'h0, 3, 4'hB, 10'h3FF, 16'h0004, 1));
    tbl.push_back(mk(0, 4'hB, 10'h3FF, 1, 0, KEYEV, 16'h0, 3, 4'hB, 10'h3FF, 16'h0004, 1));
    tbl.push_back(mk(0, 4'hB, 10'h3FE, 1, 0, KEYEV, 16'h0, 2, 4'hB, 10'h3FF, 16'h0004, 1));
    tbl.push_back(mk(0, 4'hB, 10'h3FF, 1, 0, KEYEV, 16'h0, 2, 4'hB, 10'h3FF, 16'h0004, 1));
    tbl.push_back(mk(0, 4'hB, 10'h3FF, 1, 0, KEYEV, 16'h0, 6, 4'hB, 10'h3FF, 16'h0004, 1));
    tbl.push_back(mk(0, 4'hA, 10'h3FF, 1, 0, KEYEV, 16'h0, 6, 4'hA, 10'h3FF, 16'h0005, 1));
    tbl.push_back(mk(0, 4'hA, 10'h3FF, 1, 1, KEYEV, 16'h0001, 1, 4'hA, 10'h3FF, 16'h0004, 1));
    tbl.push_back(mk(0, 4'hE, 10'h3FF, 1, 0, KEYEV, 16'h0, 6, 4'hE, 10'h3FF, rx(16'h0044, 16'h0004), 1));
    tbl.push_back(mk(0, 4'hA, 10'h3FF, 1, 0, KEYEV, 16'h0, 5, 4'hE, 10'h3FF, rx(16'h0044, 16'h0004), 1));
    tbl.push_back(mk(0, 4'hA, 10'h3FF, 1, 1, KEYEV, 16'h0004, 1, 4'hA, 10'h3FF, rx(16'h0044, 16'h0004), 1));
    tbl.push_back(mk(0, 4'hA, 10'h3FF, 1, 0, IO_KEY, 16'h0, 0, 4'hA, 10'h3FF, 16'h0000, 1));
    tbl.push_back(mk(0, 4'hA, 10'h3FF, 1, 1, IO_KEY, 16'hFFFF, 1, 4'hA, 10'h3FF, 16'h0000, 1));
    tbl.push_back(mk(0, 4'hA, 10'h3FF, 1, 0, KEYEV, 16'h0, 0, 4'hA, 10'h3FF, rx(16'h0044, 16'h0004), 1));
    tbl.push_back(mk(0, 4'hA, 10'h3FF, 1, 1, KEYEV, 16'hFFFF, 1, 4'hA, 10'h3FF, 16'h0000, 0));
    tbl.push_back(mk(0, 4'h8, 10'h3FF, 1, 0, KEYEV, 16'h0, 6, 4'h8, 10'h3FF, 16'h0002, 1));
    tbl.push_back(mk(0, 4'hA, 10'h3FF, 1, 0, KEYEV, 16'h0, 6, 4'hA, 10'h3FF, rx(16'h0022, 16'h0002), 1));
    tbl.push_back(mk(0, 4'hA, 10'h3FF, 1, 1, KEYEV, 16'h0020, 1, 4'hA, 10'h3FF, 16'h0002, 1));
    tbl.push_back(mk(0, 4'h2, 10'h3FF, 1, 0, KEYEV, 16'h0, 3, 4'hA, 10'h3FF, 16'h0002, 1));
    tbl.push_back(mk(1, 4'hF, 10'h000, 1, 0, KEYEV, 16'h0, 2, 4'hF, 10'h000, 16'h0000, 0));
    tbl.push_back(mk(0, 4'hF, 10'h000, 1, 0, KEYEV, 16'h0, 8, 4'hF, 10'h000, 16'h0000, 0));

    foreach (tbl[i]) begin
      reset      = tbl[i].rst;
      key_raw    = tbl[i].kr;
      sw_raw     = tbl[i].sr;
      io.io_rd   = tbl[i].rd;
      io.io_wr   = tbl[i].wr;
      io.io_addr = tbl[i].addr;
      io.io_dout = tbl[i].dout;
      if (tbl[i].n == 0) #1;
      else repeat (tbl[i].n) tick();
      check($sformatf("row%0d key_db", i), {12'h000, key_db}, {12'h000, tbl[i].ek});
      check($sformatf("row%0d sw_db", i), {6'h00, sw_db}, {6'h00, tbl[i].es});
      check($sformatf("row%0d io_din", i), io.io_din, tbl[i].ed);
      check($sformatf("row%0d key_irq", i), {15'h0, key_irq}, {15'h0, tbl[i].ei});
    end

    for (int t = 0; t < 1500; t++) begin
      reset = ($urandom_range(199) == 0);
      for (int c = 0; c < 4; c++)
        if ($urandom_range(5) == 0) key_raw[c] = ~key_raw[c];
      for (int c = 0; c < 10; c++)
        if ($urandom_range(5) == 0) sw_raw[c] = ~sw_raw[c];
      io.io_rd   = 1'($urandom_range(1));
      io.io_addr = ($urandom_range(3) == 0) ? IO_SW : KEYEV;
      io.io_wr   = ($urandom_range(7) == 0);
      io.io_dout = 16'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
